// File: rtl/decode_queue_pkg.sv
// Shared types for the decode queue: opcode constants, decoded-field struct,
// instruction format enum and the stored entry layout.
package decode_queue_pkg;

    localparam int MAX_XLEN = 64;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef enum logic [2:0] {
        instr_type_r,
        instr_type_i,
        instr_type_s,
        instr_type_sb,
        instr_type_u,
        instr_type_uj
    } instr_type_t;

    typedef struct packed {
        logic [6:0] opcode;
        logic [4:0] rd;
        logic [2:0] funct3;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [6:0] funct7;
    } decoded_instr_t;

    // imm and pc are held at the widest supported XLEN; users slice them down.
    typedef struct packed {
        decoded_instr_t         dec;
        instr_type_t            itype;
        logic [MAX_XLEN-1:0]    imm;
        logic [MAX_XLEN-1:0]    pc;
        logic                   illegal;
    } decoded_entry_t;

endpackage

// File: rtl/decode_queue_instr_decoder.sv
// Combinational RV32I/Zicsr/fence decoder: raw word in, queue entry out.
// Illegal encodings produce zeroed fields and I format.
module instr_decoder
    import decode_queue_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    output decoded_entry_t  entry
);

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm32;
    instr_type_t itype;
    logic        illegal;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];

    always_comb begin
        itype   = instr_type_i;
        imm32   = {{20{instr[31]}}, instr[31:20]};
        illegal = 1'b0;
        case (opcode)
            OPC_LOAD: illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
            OPC_MISC_MEM: illegal = 1'b0;
            OPC_OP_IMM: begin
                if (f3 == 3'b001)
                    illegal = (f7 != 7'b0000000);
                else if (f3 == 3'b101)
                    illegal = (f7 != 7'b0000000) && (f7 != 7'b0100000);
            end
            OPC_AUIPC, OPC_LUI: begin
                itype = instr_type_u;
                imm32 = {instr[31:12], 12'b0};
            end
            OPC_STORE: begin
                itype   = instr_type_s;
                imm32   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                illegal = (f3 > 3'b010);
            end
            OPC_OP: begin
                itype   = instr_type_r;
                imm32   = '0;
                illegal = !((f7 == 7'b0000000) ||
                            ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101))));
            end
            OPC_BRANCH: begin
                itype   = instr_type_sb;
                imm32   = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
                illegal = (f3 == 3'b010) || (f3 == 3'b011);
            end
            OPC_JALR: illegal = (f3 != 3'b000);
            OPC_JAL: begin
                itype = instr_type_uj;
                imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            OPC_SYSTEM: begin
                // Only ecall, ebreak and mret are accepted in the funct3=000 space.
                if (f3 == 3'b100)
                    illegal = 1'b1;
                else if (f3 == 3'b000)
                    illegal = !((instr == 32'h0000_0073) || (instr == 32'h0010_0073) ||
                                (instr == 32'h3020_0073));
            end
            default: illegal = 1'b1;
        endcase
        if (instr[1:0] != 2'b11)
            illegal = 1'b1;
    end

    always_comb begin
        entry         = '0;
        entry.pc      = MAX_XLEN'(pc);
        entry.illegal = illegal;
        entry.itype   = instr_type_i;
        if (!illegal) begin
            entry.dec.opcode = opcode;
            entry.dec.rd     = instr[11:7];
            entry.dec.funct3 = f3;
            entry.dec.rs1    = instr[19:15];
            entry.dec.rs2    = instr[24:20];
            entry.dec.funct7 = f7;
            entry.itype      = itype;
            entry.imm        = MAX_XLEN'($signed(imm32));
        end
    end

endmodule

// File: rtl/decode_queue.sv
// Decoded-instruction FIFO: decodes on push, presents the head entry registered.
// Handshake: a transfer happens on a rising edge where valid & ready & !flush.
module decode_queue
    import decode_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_instr,
    input  logic [XLEN-1:0]          in_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output decoded_instr_t           out_dec,
    output instr_type_t              out_type,
    output logic [XLEN-1:0]          out_imm,
    output logic [XLEN-1:0]          out_pc,
    output logic                     out_illegal,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             push;
    logic             pop;
    decoded_entry_t   new_entry;
    decoded_entry_t   head;
    decoded_entry_t   mem [DEPTH];
    logic             unused_head;

    instr_decoder #(.XLEN(XLEN)) u_decoder (
        .instr (in_instr),
        .pc    (in_pc),
        .entry (new_entry)
    );

    assign in_ready  = (count_q < CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;
    assign count     = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Payload storage carries no reset; out_valid qualifies it.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= new_entry;
    end

    assign head        = mem[rd_ptr];
    assign out_dec     = head.dec;
    assign out_type    = head.itype;
    assign out_imm     = head.imm[XLEN-1:0];
    assign out_pc      = head.pc[XLEN-1:0];
    assign out_illegal = head.illegal;
    assign unused_head = ^{head.imm, head.pc};

endmodule
